apb_bridge_ctrl: RTL and testbench

- APB master controller stage of the AHB-to-APB bridge.
- Sits between the AHB slave-side pipeline and the APB bus: consumes one latched AHB transfer at a time and drives the APB2 protocol to one of four slaves.
- Decodes the slave select, sequences SETUP/ENABLE, captures Prdata and returns a single-cycle response to the AHB side.
- APB2 only: no Pready, no Pslverr. Every APB access is exactly SETUP + ENABLE.

---
 rtl/apb_bridge_pkg.sv | 20 ++
 rtl/apb_addr_decode.sv | 19 +
 rtl/apb_bridge_ctrl.sv | 147 ++++++++++++++
 tb/tb_apb_bridge_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and defaults for the AHB-to-APB bridge controller.
// Bridge build option: APB_BACK2BACK_EN (accept the next transfer in RESP).
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ENABLE = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int          NUM_SLAVES     = 4;
    localparam logic [31:0] DEF_BASE_ADDR  = 32'h8000_0000;
    localparam int          DEF_REGION_LSB = 26;

    function automatic logic [NUM_SLAVES-1:0] slave_onehot(input logic [1:0] idx);
        slave_onehot = {{(NUM_SLAVES-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave decode: window hit flag and one-hot select for the
// four 2^REGION_LSB-byte slave regions that start at BASE_ADDR.
module apb_addr_decode
    import apb_bridge_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int                REGION_LSB = DEF_REGION_LSB
) (
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  o_in_range,
    output logic [NUM_SLAVES-1:0] o_sel
);

    // Everything above the 2-bit slave index must match the window base.
    assign o_in_range = (i_addr[ADDR_W-1:REGION_LSB+2] == BASE_ADDR[ADDR_W-1:REGION_LSB+2]);
    assign o_sel      = slave_onehot(i_addr[REGION_LSB+1:REGION_LSB]);

endmodule

// File: rtl/apb_bridge_ctrl.sv
// APB2 master stage of the AHB-to-APB bridge: one transfer at a time,
// SETUP + ENABLE per access. Build option: APB_BACK2BACK_EN.
module apb_bridge_ctrl
    import apb_bridge_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int                REGION_LSB = DEF_REGION_LSB
) (
    input  logic                  clock,
    input  logic                  reset,
    // Request side: a transfer moves when req_valid && req_ready at a rising
    // edge; the requester holds its fields stable until then. The response
    // is a one-cycle rsp_valid pulse with no backpressure.
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  req_write,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_W-1:0]     Paddr,
    output logic [DATA_W-1:0]     Pwdata,
    output logic                  Pwrite,
    output logic [NUM_SLAVES-1:0] Pselx,
    output logic                  Penable,
    input  logic [DATA_W-1:0]     Prdata,
    output apb_state_e            dbg_state
);

    apb_state_e            r_state;
    apb_state_e            w_state_nxt;
    logic                  r_live;
    logic                  w_in_range;
    logic [NUM_SLAVES-1:0] w_sel;
    logic                  w_can_accept;
    logic                  w_accept;

    logic [ADDR_W-1:0]     r_paddr;
    logic [DATA_W-1:0]     r_pwdata;
    logic                  r_pwrite;
    logic [NUM_SLAVES-1:0] r_psel;
    logic                  r_penable;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rdata;
    logic                  r_rsp_err;

    apb_addr_decode #(
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (BASE_ADDR),
        .REGION_LSB (REGION_LSB)
    ) u_decode (
        .i_addr     (req_addr),
        .o_in_range (w_in_range),
        .o_sel      (w_sel)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_can_accept = 1'b0;
        w_state_nxt  = r_state;
        case (r_state)
            IDLE: begin
                // r_live keeps req_ready low until the first edge after reset.
                w_can_accept = r_live;
                if (r_live && req_valid) begin
                    w_state_nxt = w_in_range ? SETUP : RESP;
                end
            end
            SETUP: begin
                w_state_nxt = ENABLE;
            end
            ENABLE: begin
                w_state_nxt = RESP;
            end
            RESP: begin
`ifdef APB_BACK2BACK_EN
                w_can_accept = 1'b1;
                if (req_valid) begin
                    w_state_nxt = w_in_range ? SETUP : RESP;
                end else begin
                    w_state_nxt = IDLE;
                end
`else
                w_state_nxt = IDLE;
`endif
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_accept = w_can_accept && req_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_live      <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            // Address phase fields hold between transfers; only the strobes drop.
            if (w_accept) begin
                r_paddr  <= req_addr;
                r_pwrite <= req_write;
                r_pwdata <= req_wdata;
            end
            if (w_state_nxt == SETUP) begin
                r_psel <= w_sel;
            end else if (w_state_nxt != ENABLE) begin
                r_psel <= '0;
            end
            r_penable   <= (w_state_nxt == ENABLE);
            r_rsp_valid <= (w_state_nxt == RESP);
            r_rsp_err   <= w_accept && !w_in_range;
            r_rsp_rdata <= (r_state == ENABLE && !r_pwrite) ? Prdata : '0;
        end
    end

    assign req_ready = w_can_accept;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign Paddr     = r_paddr;
    assign Pwdata    = r_pwdata;
    assign Pwrite    = r_pwrite;
    assign Pselx     = r_psel;
    assign Penable   = r_penable;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// Bench for apb_bridge_ctrl: directed scenarios plus random transfers checked
// against a transaction-level timing model. Honours APB_BACK2BACK_EN.
module tb_apb_bridge_ctrl;
    import apb_bridge_pkg::*;

    localparam int MAXC = 512;
    localparam logic [63:0] WIN_BASE = 64'h8000_0000;
    localparam logic [63:0] WIN_SIZE = 64'h0400_0000;
`ifdef APB_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Pwrite;
    logic [3:0]  Pselx;
    logic        Penable;
    logic [31:0] Prdata;
    apb_state_e  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q_addr[$];
    logic        q_write[$];
    logic [31:0] q_wdata[$];
    int          q_gap[$];
    bit          q_hold[$];
    logic [32:0] exp_q[$];
    int          onset_q[$];
    int          rsp_cyc_q[$];
    logic [31:0] rsp_dat_q[$];
    int          psel_cycles;
    bit          fixed_en;
    logic [31:0] fixed_val;

    apb_bridge_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Pwrite    (Pwrite),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Prdata    (Prdata),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_q();
        q_addr.delete();
        q_write.delete();
        q_wdata.delete();
        q_gap.delete();
        q_hold.delete();
    endtask

    task automatic add_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input int gap, input bit hold);
        q_addr.push_back(a);
        q_write.push_back(w);
        q_wdata.push_back(d);
        q_gap.push_back(gap);
        q_hold.push_back(hold);
    endtask

    // Transaction-level model: from each request and the protocol's fixed
    // latencies, derive per-cycle expectations, then drive and compare.
    // Cycle 0 is the current cycle; the DUT must be idle and ready there.
    task automatic run_seq(input string name);
        int          n = q_addr.size();
        int          acc[$];
        int          ear[$];
        int          e = 0;
        int          k = 0;
        int          lat = -1;
        logic [3:0]  prev_psel = 4'h0;
        logic [3:0]  e_psel[MAXC];
        bit          e_pen[MAXC];
        bit          e_rv[MAXC];
        bit          e_ready[MAXC];
        logic [31:0] prd[MAXC];
        onset_q.delete();
        rsp_cyc_q.delete();
        rsp_dat_q.delete();
        exp_q.delete();
        psel_cycles = 0;
        for (int c = 0; c < MAXC; c++) begin
            e_psel[c]  = 4'h0;
            e_pen[c]   = 1'b0;
            e_rv[c]    = 1'b0;
            e_ready[c] = 1'b1;
            prd[c]     = fixed_en ? fixed_val : $urandom;
        end
        for (int j = 0; j < n; j++) begin
            logic [63:0] a64;
            int          a;
            int          sl;
            a64 = {32'd0, q_addr[j]};
            ear.push_back(e);
            a = e + q_gap[j];
            acc.push_back(a);
            if (a64 >= WIN_BASE && a64 < WIN_BASE + 4 * WIN_SIZE) begin
                sl = int'((a64 - WIN_BASE) / WIN_SIZE);
                e_psel[a+1]  = 4'(1 << sl);
                e_psel[a+2]  = 4'(1 << sl);
                e_pen[a+2]   = 1'b1;
                e_rv[a+3]    = 1'b1;
                e_ready[a+1] = 1'b0;
                e_ready[a+2] = 1'b0;
                e_ready[a+3] = B2B;
                exp_q.push_back({1'b0, q_write[j] ? 32'h0 : prd[a+2]});
                e = a + (B2B ? 3 : 4);
            end else begin
                e_rv[a+1]    = 1'b1;
                e_ready[a+1] = B2B;
                exp_q.push_back({1'b1, 32'h0});
                e = a + (B2B ? 1 : 2);
            end
        end
        for (int c = 0; c <= e; c++) begin
            logic [32:0] er;
            while (k < n && acc[k] < c) k++;
            if (k < n && (c == acc[k] ||
                (q_hold[k] && c > (k == 0 ? -1 : acc[k-1]) && c < ear[k]))) begin
                req_valid = 1'b1;
                req_addr  = q_addr[k];
                req_write = q_write[k];
                req_wdata = q_wdata[k];
            end else begin
                req_valid = 1'b0;
                req_addr  = $urandom;
                req_write = 1'($urandom);
                req_wdata = $urandom;
            end
            Prdata = prd[c];
            while (lat + 1 < n && acc[lat+1] < c) lat++;
            chk($sformatf("%s c%0d req_ready", name, c), 32'(req_ready), 32'(e_ready[c]));
            chk($sformatf("%s c%0d Pselx", name, c), 32'(Pselx), 32'(e_psel[c]));
            chk($sformatf("%s c%0d Penable", name, c), 32'(Penable), 32'(e_pen[c]));
            chk($sformatf("%s c%0d rsp_valid", name, c), 32'(rsp_valid), 32'(e_rv[c]));
            if (lat >= 0) begin
                chk($sformatf("%s c%0d Paddr", name, c), Paddr, q_addr[lat]);
                chk($sformatf("%s c%0d Pwrite", name, c), 32'(Pwrite), 32'(q_write[lat]));
                chk($sformatf("%s c%0d Pwdata", name, c), Pwdata, q_wdata[lat]);
            end
            if (Pselx !== 4'h0) psel_cycles++;
            if (Pselx !== 4'h0 && prev_psel === 4'h0) onset_q.push_back(c);
            prev_psel = Pselx;
            if (rsp_valid === 1'b1) begin
                rsp_cyc_q.push_back(c);
                rsp_dat_q.push_back(rsp_rdata);
                chk($sformatf("%s c%0d rsp_expected", name, c), 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    er = exp_q.pop_front();
                    chk($sformatf("%s c%0d rsp_err", name, c), 32'(rsp_err), 32'(er[32]));
                    if (!er[32]) chk($sformatf("%s c%0d rsp_rdata", name, c), rsp_rdata, er[31:0]);
                end
            end
            tick();
        end
        req_valid = 1'b0;
        chk($sformatf("%s responses_missing", name), 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int          exp_on[4];
        logic [31:0] bnd[4];
        bnd = '{32'h8000_0000, 32'h8FFF_FFFF, 32'h7FFF_FFFF, 32'h9000_0000};
        reset = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        Prdata    = '0;
        fixed_en  = 1'b0;
        fixed_val = '0;

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        chk("rst Pselx", 32'(Pselx), 32'h0);
        chk("rst Penable", 32'(Penable), 32'h0);
        chk("rst Pwrite", 32'(Pwrite), 32'h0);
        chk("rst Paddr", Paddr, 32'h0);
        chk("rst Pwdata", Pwdata, 32'h0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst rsp_rdata", rsp_rdata, 32'h0);
        chk("rst rsp_err", 32'(rsp_err), 32'h0);
        chk("rst state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        #1;
        chk("rst ready_before_clk", 32'(req_ready), 32'h0);
        tick();
        chk("rst ready_after_clk", 32'(req_ready), 32'h1);

        // Directed write to slave 1
        clear_q();
        add_req(32'h8400_0010, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);
        run_seq("wr");
        chk("wr psel_cycles", 32'(psel_cycles), 32'd2);
        chk("wr onset", 32'(onset_q.size() > 0 ? onset_q[0] : -1), 32'd1);
        chk("wr rsp_cycle", 32'(rsp_cyc_q.size() > 0 ? rsp_cyc_q[0] : -1), 32'd3);

        // Directed read from slave 3 with a fixed slave value
        clear_q();
        fixed_en  = 1'b1;
        fixed_val = 32'h1234_5678;
        add_req(32'h8C00_0004, 1'b0, 32'h0, 0, 1'b0);
        run_seq("rd");
        fixed_en = 1'b0;
        chk("rd rsp_cycle", 32'(rsp_cyc_q.size() > 0 ? rsp_cyc_q[0] : -1), 32'd3);
        chk("rd rsp_rdata", rsp_dat_q.size() > 0 ? rsp_dat_q[0] : 32'hFFFF_FFFF, 32'h1234_5678);

        // Out-of-window request
        clear_q();
        add_req(32'h9000_0000, 1'b0, 32'h0, 0, 1'b0);
        run_seq("oor");
        chk("oor psel_cycles", 32'(psel_cycles), 32'd0);
        chk("oor rsp_cycle", 32'(rsp_cyc_q.size() > 0 ? rsp_cyc_q[0] : -1), 32'd1);

        // Back-to-back reads, valid held high
`ifdef APB_BACK2BACK_EN
        exp_on = '{1, 4, 7, 10};
`else
        exp_on = '{1, 5, 9, 13};
`endif
        clear_q();
        for (int s = 0; s < 4; s++) add_req(32'h8000_0000 + 32'(s) * 32'h0400_0000, 1'b0, 32'h0, 0, 1'b1);
        run_seq("b2b");
        chk("b2b onset_count", 32'(onset_q.size()), 32'd4);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("b2b onset%0d", s), 32'(onset_q.size() > s ? onset_q[s] : -1), 32'(exp_on[s]));
        end

        // Reset asserted during ENABLE of a write
        req_valid = 1'b1;
        req_addr  = 32'h8800_0020;
        req_write = 1'b1;
        req_wdata = 32'hCAFE_F00D;
        chk("mid ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 1'b0;
        chk("mid setup Pselx", 32'(Pselx), 32'h4);
        tick();
        chk("mid enable Penable", 32'(Penable), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid Pselx", 32'(Pselx), 32'h0);
        chk("mid Penable", 32'(Penable), 32'h0);
        chk("mid rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid state", 32'(dbg_state), 32'(IDLE));
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("mid hold%0d rsp_valid", i), 32'(rsp_valid), 32'h0);
        end
        reset = 1'b0;
        #1;
        chk("mid ready_before_clk", 32'(req_ready), 32'h0);
        tick();
        chk("mid ready_after_clk", 32'(req_ready), 32'h1);
        chk("mid no_rsp", 32'(rsp_valid), 32'h0);
        chk("mid Paddr_reset", Paddr, 32'h0);
        clear_q();
        add_req(32'h8000_0040, 1'b0, 32'h0, 0, 1'b0);
        run_seq("post_rst");

        // Random traffic, mixed windows, gaps and held requests
        for (int b = 0; b < 4; b++) begin
            clear_q();
            for (int i = 0; i < 10; i++) begin
                logic [31:0] a;
                case ($urandom_range(0, 5))
                    0, 1, 2: a = 32'h8000_0000 + $urandom_range(0, 32'h0FFF_FFFF);
                    3:       a = $urandom;
                    4:       a = bnd[$urandom_range(0, 3)];
                    default: a = 32'h8000_0000 | ($urandom & 32'h0C00_00FC);
                endcase
                add_req(a, 1'($urandom), $urandom, $urandom_range(0, 2), 1'($urandom));
            end
            run_seq($sformatf("rnd%0d", b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
